// File: rtl/sc_lane_scheduler_pkg.sv
// Purpose : shared constants for the lane scheduler: state encoding, level commands, lane period table.
// Latency : n/a (package only).
// Backpressure: n/a.
package sc_lane_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } scState_t;

    // Commands from the main state machine.
    localparam logic [2:0] TR_NONE  = 3'b000;
    localparam logic [2:0] TR_L1    = 3'b001;
    localparam logic [2:0] TR_L2    = 3'b010;
    localparam logic [2:0] TR_L3    = 3'b011;
    localparam logic [2:0] TR_L4    = 3'b100;
    localparam logic [2:0] TR_FINAL = 3'b101;

    // Base tick counts per lane at level 1; lanes beyond the table use BASE_DEFAULT.
    localparam int NUM_BASE              = 4;
    localparam int BASE_PERIOD [NUM_BASE] = '{12, 10, 14, 9};
    localparam int BASE_DEFAULT          = 8;
    localparam int LEVEL_STEP            = 2;

    function automatic logic isLevelCmd(input logic [2:0] tr);
        return (tr >= TR_L1) && (tr <= TR_L4);
    endfunction

    // Each level speeds every lane up by LEVEL_STEP base ticks, never below one tick.
    function automatic int lanePeriod(input int lane, input int level);
        int base;
        int p;
        base = (lane < NUM_BASE) ? BASE_PERIOD[lane % NUM_BASE] : BASE_DEFAULT;
        p = base - LEVEL_STEP * (level - 1);
        return (p < 1) ? 1 : p;
    endfunction

    // Staggered first countdown so lanes do not all move in phase.
    function automatic int lanePreload(input int lane, input int period);
        return 1 + (lane % period);
    endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// Purpose : one lane's countdown; loads a start value, decrements per step, reloads its period and pulses at 1.
// Latency : laneTick is registered, high the cycle after the step that found the counter at 1.
// Backpressure: none; step is simply withheld by the scheduler while frozen.
// Ports   : clock/reset, load + loadValue (start count), period (reload value), step (base tick), laneTick (pulse).
module sc_lane_counter #(
    parameter int CNT_W = 5
) (
    input  logic             SC_LANE_COUNTER_CLOCK_50,
    input  logic             SC_LANE_COUNTER_RESET_InHigh,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic [CNT_W-1:0] period,
    input  logic             step,
    output logic             laneTick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge SC_LANE_COUNTER_CLOCK_50 or posedge SC_LANE_COUNTER_RESET_InHigh) begin
        if (SC_LANE_COUNTER_RESET_InHigh) begin
            count    <= '0;
            laneTick <= 1'b0;
        end else begin
            laneTick <= 1'b0;
            if (load) begin
                count <= loadValue;
            end else if (step) begin
                // <= 1 rather than == 1 so a never-loaded zero count cannot wrap around.
                if (count <= CNT_W'(1)) begin
                    count    <= period;
                    laneTick <= 1'b1;
                end else begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sc_lane_scheduler.sv
// Purpose : schedules per-lane obstacle move pulses from a prescaled base tick; IDLE/LOAD/RUN/DONE FSM.
// Latency : first pulse of lane i in RUN cycle period_i*PRESCALE (RUN cycle 0 = first RUN cycle).
// Backpressure: hold_InLow low freezes prescaler and lanes and masks pulses; commands override hold.
// Ports   : CLOCK_50, RESET_InHigh (async), transition_InBUS (level cmd), hold_InLow,
//           laneTick_OutBUS (per-lane pulse), level_OutBUS, running_OutHigh, done_OutHigh.
// Build   : define SC_LANE_SCHEDULER_STAGGER_EN to offset initial lane phases.
module sc_lane_scheduler #(
    parameter int PRESCALE  = 2500000,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 5
) (
    input  logic                 SC_LANE_SCHEDULER_CLOCK_50,
    input  logic                 SC_LANE_SCHEDULER_RESET_InHigh,
    input  logic [2:0]           SC_LANE_SCHEDULER_transition_InBUS,
    input  logic                 SC_LANE_SCHEDULER_hold_InLow,
    output logic [NUM_LANES-1:0] SC_LANE_SCHEDULER_laneTick_OutBUS,
    output logic [2:0]           SC_LANE_SCHEDULER_level_OutBUS,
    output logic                 SC_LANE_SCHEDULER_running_OutHigh,
    output logic                 SC_LANE_SCHEDULER_done_OutHigh
);
    import sc_lane_scheduler_pkg::*;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    scState_t              state;
    scState_t              nextState;
    logic [2:0]            level;
    logic [PS_W-1:0]       prescaler;
    logic                  levelCmd;
    logic                  finalCmd;
    logic                  active;
    logic                  baseTick;
    logic                  laneStep;
    logic                  running;
    logic                  done;
    logic [NUM_LANES-1:0]  laneTickQ;

    assign levelCmd = isLevelCmd(SC_LANE_SCHEDULER_transition_InBUS);
    assign finalCmd = (SC_LANE_SCHEDULER_transition_InBUS == TR_FINAL);

    always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or posedge SC_LANE_SCHEDULER_RESET_InHigh) begin
        if (SC_LANE_SCHEDULER_RESET_InHigh) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        running   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_LOAD: nextState = finalCmd ? ST_DONE : ST_RUN;
            ST_RUN: begin
                running = SC_LANE_SCHEDULER_hold_InLow;
                if (finalCmd) nextState = ST_DONE;
            end
            ST_DONE: done = 1'b1;
            default: nextState = ST_IDLE;
        endcase
        // A new level wins from every state, ahead of hold and pending ticks.
        if (levelCmd) nextState = ST_LOAD;
    end

    // Counting only advances in unheld RUN with no command about to leave RUN,
    // so a tick due on a command cycle is dropped rather than emitted in LOAD/DONE.
    assign active   = (state == ST_RUN) && SC_LANE_SCHEDULER_hold_InLow && !levelCmd && !finalCmd;
    assign baseTick = (prescaler == PS_W'(PRESCALE - 1));
    assign laneStep = active && baseTick;

    always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or posedge SC_LANE_SCHEDULER_RESET_InHigh) begin
        if (SC_LANE_SCHEDULER_RESET_InHigh) begin
            level     <= 3'd0;
            prescaler <= '0;
        end else begin
            if (levelCmd) level <= SC_LANE_SCHEDULER_transition_InBUS;
            if (state == ST_LOAD) begin
                prescaler <= '0;
            end else if (active) begin
                prescaler <= baseTick ? '0 : prescaler + PS_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] preload;

        assign period = CNT_W'(lanePeriod(i, int'(level)));
`ifdef SC_LANE_SCHEDULER_STAGGER_EN
        assign preload = CNT_W'(lanePreload(i, lanePeriod(i, int'(level))));
`else
        assign preload = period;
`endif

        sc_lane_counter #(.CNT_W(CNT_W)) uCounter (
            .SC_LANE_COUNTER_CLOCK_50     (SC_LANE_SCHEDULER_CLOCK_50),
            .SC_LANE_COUNTER_RESET_InHigh (SC_LANE_SCHEDULER_RESET_InHigh),
            .load                         (state == ST_LOAD),
            .loadValue                    (preload),
            .period                       (period),
            .step                         (laneStep),
            .laneTick                     (laneTickQ[i])
        );
    end

    // Pulses are registered but gated by the live hold so a freeze silences them at once.
    assign SC_LANE_SCHEDULER_laneTick_OutBUS  = running ? laneTickQ : '0;
    assign SC_LANE_SCHEDULER_level_OutBUS     = level;
    assign SC_LANE_SCHEDULER_running_OutHigh  = running;
    assign SC_LANE_SCHEDULER_done_OutHigh     = done;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
module tb_sc_lane_scheduler;

    localparam int NL = 4;

    logic          clk;
    logic          rst;
    logic [2:0]    tr;
    logic          hold;
    logic [NL-1:0] laneTick;
    logic [2:0]    level;
    logic          running;
    logic          done;

    int nCmp;
    int nFail;

    int firstCyc [NL];
    int nPulse   [NL];
    int holdBad;
    int runBad;

    typedef struct {
        logic       r;
        logic [2:0] t;
        logic       h;
        int         expLevel;
        int         expRun;
        int         expDone;
        int         expTick;
    } vec_t;

    vec_t vecs [20];

    sc_lane_scheduler #(.PRESCALE(4), .NUM_LANES(NL), .CNT_W(5)) dut (
        .SC_LANE_SCHEDULER_CLOCK_50        (clk),
        .SC_LANE_SCHEDULER_RESET_InHigh    (rst),
        .SC_LANE_SCHEDULER_transition_InBUS(tr),
        .SC_LANE_SCHEDULER_hold_InLow      (hold),
        .SC_LANE_SCHEDULER_laneTick_OutBUS (laneTick),
        .SC_LANE_SCHEDULER_level_OutBUS    (level),
        .SC_LANE_SCHEDULER_running_OutHigh (running),
        .SC_LANE_SCHEDULER_done_OutHigh    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock cycle: inputs change just after the edge, outputs are sampled 1 time unit later.
    task automatic cyc(input logic r, input logic [2:0] t, input logic h);
        @(posedge clk);
        #1;
        rst  = r;
        tr   = t;
        hold = h;
        #1;
    endtask

    // Runs n RUN cycles (cycle 0 first), hold low for cycles holdLo..holdHi-1, logging pulses.
    task automatic runRec(input int n, input int holdLo, input int holdHi);
        logic h;
        for (int l = 0; l < NL; l++) begin
            firstCyc[l] = -1;
            nPulse[l]   = 0;
        end
        holdBad = 0;
        runBad  = 0;
        for (int k = 0; k < n; k++) begin
            h = !((k >= holdLo) && (k < holdHi));
            cyc(1'b0, 3'b000, h);
            for (int l = 0; l < NL; l++) begin
                if (laneTick[l]) begin
                    if (firstCyc[l] < 0) firstCyc[l] = k;
                    nPulse[l]++;
                end
            end
            if (!h && (running || laneTick != '0)) holdBad++;
            if (h && !running) runBad++;
        end
    endtask

    task automatic chkLanes(input string nm, input int ef [NL], input int en [NL]);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("%s lane%0d first pulse cycle", nm, l), firstCyc[l], ef[l]);
            chk($sformatf("%s lane%0d pulse count", nm, l), nPulse[l], en[l]);
        end
        chk($sformatf("%s running low while unheld", nm), runBad, 0);
    endtask

    initial begin
        int ef [NL];
        int en [NL];
        int idleBad;

        nCmp  = 0;
        nFail = 0;
        rst   = 1'b1;
        tr    = 3'b000;
        hold  = 1'b1;

        //            rst   tr      hold  lvl run done tick
        vecs[0]  = '{1'b1, 3'b000, 1'b1, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 3'b001, 1'b1, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 3'b000, 1'b1, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 3'b000, 1'b1, 1, 1, 0, 0};
        vecs[4]  = '{1'b0, 3'b000, 1'b0, 1, 0, 0, 0};
        vecs[5]  = '{1'b0, 3'b101, 1'b1, 1, 1, 0, 0};
        vecs[6]  = '{1'b0, 3'b110, 1'b1, 1, 0, 1, 0};
        vecs[7]  = '{1'b0, 3'b000, 1'b1, 1, 0, 1, 0};
        vecs[8]  = '{1'b0, 3'b101, 1'b1, 1, 0, 1, 0};
        vecs[9]  = '{1'b0, 3'b011, 1'b1, 1, 0, 1, 0};
        vecs[10] = '{1'b0, 3'b000, 1'b1, 3, 0, 0, 0};
        vecs[11] = '{1'b0, 3'b101, 1'b1, 3, 1, 0, 0};
        vecs[12] = '{1'b0, 3'b000, 1'b1, 3, 0, 1, 0};
        vecs[13] = '{1'b0, 3'b010, 1'b1, 3, 0, 1, 0};
        vecs[14] = '{1'b0, 3'b101, 1'b1, 2, 0, 0, 0};
        vecs[15] = '{1'b0, 3'b000, 1'b1, 2, 0, 1, 0};
        vecs[16] = '{1'b1, 3'b000, 1'b1, 0, 0, 0, 0};
        vecs[17] = '{1'b0, 3'b101, 1'b1, 0, 0, 0, 0};
        vecs[18] = '{1'b0, 3'b111, 1'b1, 0, 0, 0, 0};
        vecs[19] = '{1'b0, 3'b000, 1'b1, 0, 0, 0, 0};

        for (int v = 0; v < 20; v++) begin
            cyc(vecs[v].r, vecs[v].t, vecs[v].h);
            chk($sformatf("vec%0d level", v),    int'(level),    vecs[v].expLevel);
            chk($sformatf("vec%0d running", v),  int'(running),  vecs[v].expRun);
            chk($sformatf("vec%0d done", v),     int'(done),     vecs[v].expDone);
            chk($sformatf("vec%0d laneTick", v), int'(laneTick), vecs[v].expTick);
        end

`ifdef SC_LANE_SCHEDULER_STAGGER_EN
        // Level 1 staggered: preloads {1,2,3,4}, reload periods {48,40,56,36} cycles.
        cyc(1'b0, 3'b001, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        chk("stagger LOAD level", int'(level), 1);
        runRec(110, 0, 0);
        ef = '{4, 8, 12, 16};
        en = '{3, 3, 2, 3};
        chkLanes("stagger L1", ef, en);
`else
        // Level 1 from IDLE: periods {12,10,14,9} base ticks = {48,40,56,36} cycles.
        cyc(1'b0, 3'b001, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        chk("L1 LOAD level", int'(level), 1);
        chk("L1 LOAD running", int'(running), 0);
        runRec(80, 0, 0);
        ef = '{48, 40, 56, 36};
        en = '{1, 1, 1, 2};
        chkLanes("L1", ef, en);

        // Jump to level 4 mid-RUN, then a level command exactly when lane 3 would fire.
        cyc(1'b0, 3'b100, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        chk("L4 LOAD level", int'(level), 4);
        chk("L4 LOAD laneTick", int'(laneTick), 0);
        runRec(11, 0, 0);
        cyc(1'b0, 3'b100, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        chk("cmd over pending tick laneTick", int'(laneTick), 0);
        chk("cmd over pending tick running", int'(running), 0);
        runRec(40, 0, 0);
        ef = '{24, 16, 32, 12};
        en = '{1, 2, 1, 3};
        chkLanes("L4", ef, en);

        // Hold low for RUN cycles 20..29 at level 1 shifts every pulse by 10.
        cyc(1'b0, 3'b001, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        runRec(60, 20, 30);
        ef = '{58, 50, -1, 46};
        en = '{1, 1, 0, 1};
        chkLanes("hold", ef, en);
        chk("hold quiet", holdBad, 0);

        // Reset at RUN cycle 30, then 100 idle cycles with no command.
        cyc(1'b0, 3'b001, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        runRec(30, 0, 0);
        cyc(1'b1, 3'b000, 1'b1);
        chk("midrun reset level", int'(level), 0);
        chk("midrun reset running", int'(running), 0);
        chk("midrun reset done", int'(done), 0);
        chk("midrun reset laneTick", int'(laneTick), 0);
        idleBad = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1'b0, 3'b000, 1'b1);
            if (laneTick != '0 || running || done || level != 3'd0) idleBad++;
        end
        chk("post-reset idle", idleBad, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
